// File: rtl/mem_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// mem_seq_pkg : shared types and constants for the memory command sequencer
// Rev 1.0
// ============================================================================
package mem_seq_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// mem_cmd_seq_if : request, response and memory-pin bundle of the sequencer
// Rev 1.0
// ============================================================================
interface mem_cmd_seq_if #(
    parameter int ADDR_W = mem_seq_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_seq_pkg::DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_rdata;

    logic              mem_cen;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;

    // The sequencer is the slave of this bundle
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_addr, rsp_rdata,
               mem_cen, mem_rd, mem_wr, mem_add, mem_din, busy
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_addr, rsp_rdata,
               mem_cen, mem_rd, mem_wr, mem_add, mem_din, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_cmd_fifo.sv
`default_nettype none
// ============================================================================
// mem_cmd_fifo : small synchronous in-order request FIFO
// Rev 1.0
// ============================================================================
module mem_cmd_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/mem_cmd_seq.sv
`default_nettype none
// ============================================================================
// mem_cmd_seq : buffers read/write requests and issues them to a 4K x 8 macro
// Rev 1.0
// ============================================================================
module mem_cmd_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_cmd_seq_if.slave bus
);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W   = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

    seq_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              mem_cen_q, mem_cen_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_add_q, mem_add_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]   fifo_count;
    logic               head_wr;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               rsp_free, capture;

    assign fifo_wdata = {bus.req_wr, bus.req_addr, bus.req_wdata};
    assign fifo_push  = bus.req_valid && !fifo_full;
    assign fifo_pop   = (state_q == ISSUE);
    assign {head_wr, head_addr, head_data} = fifo_rdata;
    // A read may only go out if its response has somewhere to land
    assign rsp_free   = !rsp_valid_q || bus.rsp_ready;
    assign capture    = (state_q == WAIT) && (lat_cnt_q == LAT_LAST);

    mem_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && (head_wr == OP_WR || rsp_free)) state_d = ISSUE;
            ISSUE:   state_d = (head_wr == OP_WR) ? IDLE : WAIT;
            WAIT:    if (lat_cnt_q == LAT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory pins are registered, so they are derived from the state being entered
    always_comb begin
        mem_cen_d   = 1'b1;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_add_d   = mem_add_q;
        mem_din_d   = '0;
        lat_cnt_d   = lat_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;

        if (state_d == ISSUE) begin
            mem_cen_d = 1'b0;
            mem_add_d = head_addr;
            if (head_wr == OP_WR) begin
                mem_wr_d  = 1'b1;
                mem_din_d = head_data;
            end else begin
                mem_rd_d  = 1'b1;
            end
        end

        if (state_q == ISSUE && head_wr == OP_RD) lat_cnt_d = LAT_LOAD;
        else if (state_q == WAIT)                 lat_cnt_d = lat_cnt_q - LAT_LAST;

        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = mem_add_q;
            rsp_rdata_d = bus.mem_dout;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt_q   <= '0;
            mem_cen_q   <= 1'b1;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_add_q   <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            lat_cnt_q   <= lat_cnt_d;
            mem_cen_q   <= mem_cen_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_add_q   <= mem_add_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_cen   = mem_cen_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_add   = mem_add_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.busy      = (fifo_count != '0) || (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_seq.sv
`default_nettype none
// ============================================================================
// tb_mem_cmd_seq : directed and random checks of mem_cmd_seq against a
// transaction-level model; a second RD_LAT=3 instance covers latency timing.
// ============================================================================
module tb_mem_cmd_seq;
    import mem_seq_pkg::*;

    localparam int AW      = 12;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int RD_LAT1 = 1;
    localparam int RD_LAT3 = 3;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    always #5 clk = ~clk;

    mem_cmd_seq_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    mem_cmd_seq_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

    mem_cmd_seq #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT1))
        u_dut  (.clk(clk), .rst(rst), .bus(b1));
    mem_cmd_seq #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT3))
        u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Memory macro models: registered read, dout held until the next read
    logic [DW-1:0] mem1    [4096];
    logic [DW-1:0] mem3    [4096];
    logic [DW-1:0] ref_mem [4096];

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 7 + 3) ^ DW'(a >> 4);
    endfunction

    always @(posedge clk) begin
        if (!b1.mem_cen && b1.mem_wr) mem1[b1.mem_add] <= b1.mem_din;
        if (!b1.mem_cen && b1.mem_rd) b1.mem_dout <= mem1[b1.mem_add];
        if (!b3.mem_cen && b3.mem_wr) mem3[b3.mem_add] <= b3.mem_din;
        if (!b3.mem_cen && b3.mem_rd) b3.mem_dout <= mem3[b3.mem_add];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model (RD_LAT=1 instance) --------------
    req_t          q[$];
    bit            m_iss     = 1'b0;   // current cycle is an issue cycle for q[0]
    int            m_lat     = 0;      // edges left until the outstanding read is captured
    logic [AW-1:0] m_add     = '0;
    logic [AW-1:0] m_cur     = '0;
    logic [DW-1:0] m_rd_data = '0;
    bit            m_rsp_v   = 1'b0;
    logic [AW-1:0] m_rsp_a   = '0;
    logic [DW-1:0] m_rsp_d   = '0;

    always @(posedge clk or posedge rst) begin : model
        bit   go, cap, rsp_free, can_push;
        req_t hd;
        if (rst) begin
            q.delete();
            m_iss   = 1'b0;
            m_lat   = 0;
            m_add   = '0;
            m_rsp_v = 1'b0;
            m_rsp_a = '0;
            m_rsp_d = '0;
        end else begin
            rsp_free = !m_rsp_v || b1.rsp_ready;
            can_push = b1.req_valid && (q.size() < DEPTH);
            go  = 1'b0;
            cap = 1'b0;
            if (m_lat > 0) begin
                m_lat--;
                cap = (m_lat == 0);
            end else if (!m_iss && q.size() > 0 && (q[0].wr || rsp_free)) begin
                go = 1'b1;
            end
            if (cap) begin
                m_rsp_v = 1'b1;
                m_rsp_a = m_cur;
                m_rsp_d = m_rd_data;
            end else if (m_rsp_v && b1.rsp_ready) begin
                m_rsp_v = 1'b0;
            end
            if (m_iss) begin
                hd    = q.pop_front();
                m_cur = hd.addr;
                if (hd.wr) ref_mem[hd.addr] = hd.data;
                else begin
                    m_rd_data = ref_mem[hd.addr];
                    m_lat     = RD_LAT1;
                end
            end
            if (go) m_add = q[0].addr;
            if (can_push) begin
                hd = '{wr: b1.req_wr, addr: b1.req_addr, data: b1.req_wdata};
                q.push_back(hd);
            end
            m_iss = go;
        end
    end

    always @(negedge clk) begin : compare
        logic          hw;
        logic [DW-1:0] hd_data;
        if (chk_en) begin
            hw      = (q.size() > 0) ? q[0].wr : 1'b0;
            hd_data = (q.size() > 0) ? q[0].data : '0;
            check("req_ready", b1.req_ready, q.size() < DEPTH);
            check("mem_cen",   b1.mem_cen,   !m_iss);
            check("mem_rd",    b1.mem_rd,    m_iss && !hw);
            check("mem_wr",    b1.mem_wr,    m_iss && hw);
            check("mem_add",   b1.mem_add,   m_add);
            check("mem_din",   b1.mem_din,   (m_iss && hw) ? hd_data : '0);
            check("rsp_valid", b1.rsp_valid, m_rsp_v);
            check("rsp_addr",  b1.rsp_addr,  m_rsp_a);
            check("rsp_rdata", b1.rsp_rdata, m_rsp_d);
            check("busy",      b1.busy,      (q.size() > 0) || m_iss || (m_lat > 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_req(input bit l3, input logic v, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (l3) begin
            b3.req_valid = v; b3.req_wr = wr; b3.req_addr = a; b3.req_wdata = d;
        end else begin
            b1.req_valid = v; b1.req_wr = wr; b1.req_addr = a; b1.req_wdata = d;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input bit l3, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int g;
        g = 0;
        drive_req(l3, 1'b1, wr, a, d);
        while (!(l3 ? b3.req_ready : b1.req_ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("send_accept", l3 ? b3.req_ready : b1.req_ready, 1);
        @(negedge clk);
        drive_req(l3, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((b1.busy || b1.rsp_valid) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("idle_busy", b1.busy, 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) begin
            mem1[i]    = init_val(i);
            mem3[i]    = init_val(i);
            ref_mem[i] = init_val(i);
        end
        b1.mem_dout = '0;
        b3.mem_dout = '0;
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        b1.rsp_ready = 1'b1;
        b3.rsp_ready = 1'b1;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_mem_cen",   b1.mem_cen,   1);
        check("rst_mem_rd",    b1.mem_rd,    0);
        check("rst_mem_wr",    b1.mem_wr,    0);
        check("rst_rsp_valid", b1.rsp_valid, 0);
        check("rst_req_ready", b1.req_ready, 1);
        check("rst_busy",      b1.busy,      0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back
        send(1'b0, 1'b1, 12'h2AA, 8'hAA);
        send(1'b0, 1'b0, 12'h2AA, 8'h00);
        cyc = 0;
        while (!b1.mem_rd && cyc < 50) begin @(negedge clk); cyc++; end
        check("rd_issue",     b1.mem_rd,  1);
        check("rd_issue_add", b1.mem_add, 12'h2AA);
        cyc = 0;
        while (!b1.rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("rsp_lat1",       cyc,          2);
        check("rsp_addr_2AA",   b1.rsp_addr,  12'h2AA);
        check("rsp_rdata_2AA",  b1.rsp_rdata, 8'hAA);
        wait_idle();

        // Back-to-back writes
        for (int i = 0; i < 5; i++) send(1'b0, 1'b1, AW'(12'hB2A + i), DW'(8'h10 + i));
        wait_idle();

        // Response backpressure blocks the second read and everything behind it
        b1.rsp_ready = 1'b0;
        send(1'b0, 1'b0, 12'h2AA, 8'h00);
        send(1'b0, 1'b0, 12'hB2A, 8'h00);
        cyc = 0;
        while (!b1.rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("bp_rsp_addr",  b1.rsp_addr,  12'h2AA);
        check("bp_rsp_rdata", b1.rsp_rdata, 8'hAA);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, AW'(12'h300 + i), DW'(8'h60 + i));
        check("bp_full_ready", b1.req_ready, 0);
        repeat (4) begin
            @(negedge clk);
            check("bp_no_rd",   b1.mem_rd,    0);
            check("bp_hold_rv", b1.rsp_valid, 1);
        end
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rd2_issue", b1.mem_rd,  1);
        check("bp_rd2_add",   b1.mem_add, 12'hB2A);
        cyc = 0;
        while (!b1.rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("bp_rsp2_addr",  b1.rsp_addr,  12'hB2A);
        check("bp_rsp2_rdata", b1.rsp_rdata, 8'h10);
        wait_idle();

        // RD_LAT=3 instance
        send(1'b1, 1'b1, 12'hEAA, 8'hEA);
        send(1'b1, 1'b0, 12'hEAA, 8'h00);
        cyc = 0;
        while (!b3.mem_rd && cyc < 50) begin @(negedge clk); cyc++; end
        check("l3_rd_issue", b3.mem_rd,  1);
        check("l3_rd_add",   b3.mem_add, 12'hEAA);
        cyc = 0;
        while (!b3.rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("l3_rsp_lat",   cyc,          4);
        check("l3_rsp_addr",  b3.rsp_addr,  12'hEAA);
        check("l3_rsp_rdata", b3.rsp_rdata, 8'hEA);
        @(negedge clk);

        // Reset while a read is in flight
        send(1'b0, 1'b0, 12'hEBA, 8'h00);
        cyc = 0;
        while (!b1.mem_rd && cyc < 50) begin @(negedge clk); cyc++; end
        check("rr_rd_issue", b1.mem_rd, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rr_rsp_valid", b1.rsp_valid, 0);
        check("rr_busy",      b1.busy,      0);
        check("rr_req_ready", b1.req_ready, 1);
        check("rr_mem_cen",   b1.mem_cen,   1);
        check("rr_mem_add",   b1.mem_add,   0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rr_no_rsp", b1.rsp_valid, 0);
        end

        // Randomized traffic over a small address window
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            b1.req_valid = 1'($urandom_range(0, 1));
            b1.req_wr    = 1'($urandom_range(0, 1));
            b1.req_addr  = AW'(12'h2A0 + $urandom_range(0, 7));
            b1.req_wdata = DW'($urandom);
            b1.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        b1.rsp_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
